// File: rtl/result_monitor_pkg.sv
// result_monitor_pkg: FSM state and status encodings plus record sizing.
// RESULT_MONITOR_CYCLES_EN appends a 4-byte cycle stamp to every record.
package result_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        REPORT   = 2'd2,
        FINISHED = 2'd3
    } state_t;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_DONE = 2'b01;
    localparam logic [1:0] ST_ERR  = 2'b10;

    localparam int unsigned STAMP_W = 32;

`ifdef RESULT_MONITOR_CYCLES_EN
    localparam int unsigned STAMP_BYTES = 4;
`else
    localparam int unsigned STAMP_BYTES = 0;
`endif

    // Bytes in one channel record: header, answer bytes, optional stamp.
    function automatic int unsigned record_bytes(input int unsigned ans_w);
        return 1 + (ans_w + 7) / 8 + STAMP_BYTES;
    endfunction

endpackage

// File: rtl/result_monitor_if.sv
// result_monitor_if: byte-wide valid/ready stream from the monitor to the host sink.
interface result_monitor_if;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;

    modport master (output TxData, output TxValid, input TxReady);
    modport slave  (input TxData, input TxValid, output TxReady);
endinterface

// File: rtl/result_serializer.sv
// result_serializer: turns (record, byte) indices into record bytes and owns the
// one-deep output register with valid/ready hold.
// RESULT_MONITOR_CYCLES_EN adds the stamp input and stamp bytes.
module result_serializer
    import result_monitor_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ANS_W  = 64,
    parameter int unsigned CH_W   = 1,
    parameter int unsigned BI_W   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic [CH_W-1:0]           rec_idx_i,
    input  logic [BI_W-1:0]           byte_idx_i,
    input  logic [2*NUM_CH-1:0]       status_i,
    input  logic [NUM_CH*ANS_W-1:0]   answer_i,
`ifdef RESULT_MONITOR_CYCLES_EN
    input  logic [NUM_CH*STAMP_W-1:0] stamp_i,
`endif
    output logic                      take_o,
    result_monitor_if.master          tx
);

    localparam int unsigned ANS_BYTES = (ANS_W + 7) / 8;

    logic [1:0]             ch_status;
    logic [ANS_W-1:0]       ch_answer;
    logic [ANS_BYTES*8-1:0] ans_pad;
    logic [7:0]             data_d;
    logic [7:0]             data_q;
    logic                   valid_q;
    logic                   slot_free;
`ifdef RESULT_MONITOR_CYCLES_EN
    logic [STAMP_W-1:0]     ch_stamp;
`endif

    // Pick the addressed channel's latched status, answer and stamp.
    always_comb begin
        ch_status = '0;
        ch_answer = '0;
`ifdef RESULT_MONITOR_CYCLES_EN
        ch_stamp  = '0;
`endif
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (rec_idx_i == CH_W'(c)) begin
                ch_status = status_i[2*c +: 2];
                ch_answer = answer_i[c*ANS_W +: ANS_W];
`ifdef RESULT_MONITOR_CYCLES_EN
                ch_stamp  = stamp_i[c*STAMP_W +: STAMP_W];
`endif
            end
        end
`ifdef RESULT_MONITOR_CYCLES_EN
        // A channel that never completed carries an all-ones stamp.
        if (ch_status == ST_NONE) begin
            ch_stamp = '1;
        end
`endif
    end

    // Byte mux: header, then answer LSB first (zero padded), then stamp.
    always_comb begin
        ans_pad = '0;
        ans_pad[ANS_W-1:0] = ch_answer;
        data_d = '0;
        if (byte_idx_i == '0) begin
            data_d = {ch_status, 6'(rec_idx_i)};
        end
        for (int unsigned b = 0; b < ANS_BYTES; b++) begin
            if (byte_idx_i == BI_W'(b + 1)) begin
                data_d = ans_pad[8*b +: 8];
            end
        end
`ifdef RESULT_MONITOR_CYCLES_EN
        for (int unsigned b = 0; b < STAMP_BYTES; b++) begin
            if (byte_idx_i == BI_W'(1 + ANS_BYTES + b)) begin
                data_d = ch_stamp[8*b +: 8];
            end
        end
`endif
    end

    assign slot_free = !valid_q || tx.TxReady;
    assign take_o    = en_i && slot_free;

    // Output register: reload only when empty or the current byte is accepted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (slot_free) begin
            valid_q <= take_o;
            if (take_o) begin
                data_q <= data_d;
            end
        end
    end

    assign tx.TxValid = valid_q;
    assign tx.TxData  = data_q;

endmodule

// File: rtl/result_monitor.sv
// result_monitor: latches first completion per solver channel, applies a global
// timeout, then streams one record per channel over result_monitor_if.
// RESULT_MONITOR_CYCLES_EN adds a per-channel completion cycle stamp.
module result_monitor
    import result_monitor_pkg::*;
#(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned ANS_W          = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Start,
    input  logic [NUM_CH-1:0]       Done,
    input  logic [NUM_CH-1:0]       Error,
    input  logic [NUM_CH*ANS_W-1:0] Answer,
    result_monitor_if.master        tx,
    output logic                    Busy,
    output logic                    Finished,
    output logic                    AnyError,
    output logic                    TimedOut,
    output logic [CNT_W-1:0]        CycleCount
);

    localparam int unsigned REC_BYTES = record_bytes(ANS_W);
    localparam int unsigned BI_W      = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_CH-1:0]       latched_q;
    logic [2*NUM_CH-1:0]     status_q;
    logic [NUM_CH*ANS_W-1:0] answer_q;
`ifdef RESULT_MONITOR_CYCLES_EN
    logic [NUM_CH*STAMP_W-1:0] stamp_q;
`endif
    logic                    any_err_q;
    logic                    timed_out_q;
    logic                    busy_q;
    logic                    finished_q;
    logic                    loaded_all_q;
    logic [CH_W-1:0]         rec_idx_q;
    logic [BI_W-1:0]         byte_idx_q;

    logic [NUM_CH-1:0]       hit;
    logic                    all_latched;
    logic                    timeout_hit;
    logic                    ser_en;
    logic                    take;

    // Channels completing this cycle, and the two RUN exit conditions.
    always_comb begin
        hit = '0;
        if (state_q == RUN) begin
            hit = ~latched_q & (Done | Error);
        end
        all_latched = &(latched_q | hit);
        timeout_hit = TO_EN && (cnt_q == TO_LAST);
    end

    assign ser_en = (state_q == REPORT) && !loaded_all_q;

    // Control FSM: arming, latching, counting and record/byte sequencing.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            latched_q    <= '0;
            status_q     <= '0;
            answer_q     <= '0;
`ifdef RESULT_MONITOR_CYCLES_EN
            stamp_q      <= '0;
`endif
            any_err_q    <= 1'b0;
            timed_out_q  <= 1'b0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            loaded_all_q <= 1'b0;
            rec_idx_q    <= '0;
            byte_idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE, FINISHED: begin
                    if (Start) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        finished_q  <= 1'b0;
                        cnt_q       <= '0;
                        latched_q   <= '0;
                        status_q    <= '0;
                        answer_q    <= '0;
`ifdef RESULT_MONITOR_CYCLES_EN
                        stamp_q     <= '0;
`endif
                        any_err_q   <= 1'b0;
                        timed_out_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    for (int unsigned c = 0; c < NUM_CH; c++) begin
                        if (hit[c]) begin
                            latched_q[c]                <= 1'b1;
                            status_q[2*c +: 2]          <= Error[c] ? ST_ERR : ST_DONE;
                            answer_q[c*ANS_W +: ANS_W]  <= Answer[c*ANS_W +: ANS_W];
`ifdef RESULT_MONITOR_CYCLES_EN
                            stamp_q[c*STAMP_W +: STAMP_W] <= STAMP_W'(cnt_q);
`endif
                        end
                    end
                    if (|(hit & Error)) begin
                        any_err_q <= 1'b1;
                    end
                    // Completion on the timeout cycle wins: no TimedOut flag.
                    if (all_latched || timeout_hit) begin
                        state_q      <= REPORT;
                        timed_out_q  <= !all_latched;
                        loaded_all_q <= 1'b0;
                        rec_idx_q    <= '0;
                        byte_idx_q   <= '0;
                    end
                end
                REPORT: begin
                    if (take) begin
                        if (byte_idx_q == BI_W'(REC_BYTES - 1)) begin
                            byte_idx_q <= '0;
                            if (rec_idx_q == CH_W'(NUM_CH - 1)) begin
                                loaded_all_q <= 1'b1;
                            end else begin
                                rec_idx_q <= rec_idx_q + 1'b1;
                            end
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                        end
                    end
                    // The final byte sits in the output register once all are loaded.
                    if (loaded_all_q && tx.TxValid && tx.TxReady) begin
                        state_q    <= FINISHED;
                        busy_q     <= 1'b0;
                        finished_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    result_serializer #(
        .NUM_CH (NUM_CH),
        .ANS_W  (ANS_W),
        .CH_W   (CH_W),
        .BI_W   (BI_W)
    ) u_ser (
        .clk_i      (Clk),
        .rst_ni     (Rst_n),
        .en_i       (ser_en),
        .rec_idx_i  (rec_idx_q),
        .byte_idx_i (byte_idx_q),
        .status_i   (status_q),
        .answer_i   (answer_q),
`ifdef RESULT_MONITOR_CYCLES_EN
        .stamp_i    (stamp_q),
`endif
        .take_o     (take),
        .tx         (tx)
    );

    assign Busy       = busy_q;
    assign Finished   = finished_q;
    assign AnyError   = any_err_q;
    assign TimedOut   = timed_out_q;
    assign CycleCount = cnt_q;

endmodule

// File: tb/tb_result_monitor.sv
// tb_result_monitor: table vectors plus randomized runs checked against a
// behavioural model of first-completion latching and record streaming.
module tb_result_monitor;

    localparam int TOC = 20;
`ifdef RESULT_MONITOR_CYCLES_EN
    localparam int STB = 4;
`else
    localparam int STB = 0;
`endif
    localparam int REC = 1 + 2 + STB;

    logic        clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic [1:0]  Done;
    logic [1:0]  Error;
    logic [31:0] Answer;
    logic        Busy, Finished, AnyError, TimedOut;
    logic [31:0] CycleCount;

    result_monitor_if bus();

    result_monitor #(
        .NUM_CH         (2),
        .ANS_W          (16),
        .TIMEOUT_CYCLES (TOC),
        .CNT_W          (32)
    ) dut (
        .Clk        (clk),
        .Rst_n      (Rst_n),
        .Start      (Start),
        .Done       (Done),
        .Error      (Error),
        .Answer     (Answer),
        .tx         (bus),
        .Busy       (Busy),
        .Finished   (Finished),
        .AnyError   (AnyError),
        .TimedOut   (TimedOut),
        .CycleCount (CycleCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         d0;
        logic [1:0] k0;   // bit0 Done, bit1 Error
        logic [15:0] a0;
        int         d1;
        logic [1:0] k1;
        logic [15:0] a1;
        logic [7:0] hdr0;
        logic [7:0] hdr1;
        bit         any;
        bit         to;
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_fail   = 0;

    bit          done_pat[2][TOC];
    bit          err_pat[2][TOC];
    logic [15:0] ans_pat[2][TOC];

    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int         m_end;
    bit         m_to;
    bit         m_any;
    int         m_lat[2];
    logic [1:0] m_st[2];

    logic        s_valid, s_busy, s_fin, s_any, s_to;
    logic [7:0]  s_data;
    logic [31:0] s_cc;
    bit          hold_pend;
    logic [7:0]  hold_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample this cycle's outputs at negedge, then advance past the next posedge.
    task automatic tick();
        @(negedge clk);
        s_valid = bus.TxValid;
        s_data  = bus.TxData;
        s_busy  = Busy;
        s_fin   = Finished;
        s_any   = AnyError;
        s_to    = TimedOut;
        s_cc    = CycleCount;
        if (hold_pend) begin
            check("hold_valid", s_valid, 1);
            check("hold_data", s_data, hold_data);
        end
        hold_pend = s_valid && !bus.TxReady;
        hold_data = s_data;
        if (s_valid && bus.TxReady) got.push_back(s_data);
        @(posedge clk);
        #1;
    endtask

    // Reference: first event per channel, stop when all done or at the timeout cycle.
    task automatic model();
        logic [15:0] ans[2];
        logic [31:0] stamp;
        m_lat = '{-1, -1};
        m_st  = '{2'b00, 2'b00};
        ans   = '{16'h0, 16'h0};
        m_end = -1;
        m_to  = 1'b0;
        for (int k = 0; k < TOC && m_end < 0; k++) begin
            for (int c = 0; c < 2; c++) begin
                if (m_lat[c] < 0 && (done_pat[c][k] || err_pat[c][k])) begin
                    m_lat[c] = k;
                    m_st[c]  = err_pat[c][k] ? 2'b10 : 2'b01;
                    ans[c]   = ans_pat[c][k];
                end
            end
            if (m_lat[0] >= 0 && m_lat[1] >= 0) m_end = k;
            else if (k == TOC - 1) begin
                m_end = k;
                m_to  = 1'b1;
            end
        end
        m_any = (m_st[0] == 2'b10) || (m_st[1] == 2'b10);
        exp_q.delete();
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back({m_st[c], 6'(c)});
            exp_q.push_back(ans[c][7:0]);
            exp_q.push_back(ans[c][15:8]);
            stamp = (m_lat[c] < 0) ? 32'hFFFF_FFFF : 32'(m_lat[c]);
            for (int b = 0; b < STB; b++) exp_q.push_back(stamp[8*b +: 8]);
        end
    endtask

    function automatic bit exp_any_at(input int k);
        return (m_st[0] == 2'b10 && m_lat[0] < k) || (m_st[1] == 2'b10 && m_lat[1] < k);
    endfunction

    task automatic load_vec(input vec_t v);
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < TOC; k++) begin
                done_pat[c][k] = 1'b0;
                err_pat[c][k]  = 1'b0;
                ans_pat[c][k]  = 16'($urandom);
            end
        if (v.d0 >= 0) begin
            done_pat[0][v.d0] = v.k0[0];
            err_pat[0][v.d0]  = v.k0[1];
            ans_pat[0][v.d0]  = v.a0;
        end
        if (v.d1 >= 0) begin
            done_pat[1][v.d1] = v.k1[0];
            err_pat[1][v.d1]  = v.k1[1];
            ans_pat[1][v.d1]  = v.a1;
        end
    endtask

    task automatic load_random();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < TOC; k++) begin
                done_pat[c][k] = ($urandom_range(0, 15) == 0);
                err_pat[c][k]  = ($urandom_range(0, 31) == 0);
                ans_pat[c][k]  = 16'($urandom);
            end
    endtask

    // One armed run; abort_after > 0 applies a 1-cycle reset after that many bytes.
    task automatic run_case(input string tag, input bit rnd, input int abort_after);
        int first_v;
        bit fin;
        model();
        got.delete();
        hold_pend = 1'b0;
        first_v   = -1;
        fin       = 1'b0;
        Done = '0; Error = '0; bus.TxReady = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 300 && !fin; k++) begin
            if (k < TOC) begin
                Done   = {done_pat[1][k], done_pat[0][k]};
                Error  = {err_pat[1][k], err_pat[0][k]};
                Answer = {ans_pat[1][k], ans_pat[0][k]};
            end else begin
                Done = '0; Error = '0; Answer = 32'($urandom);
            end
            Start       = rnd && k > 0 && k <= m_end + 1 && ($urandom_range(0, 7) == 0);
            bus.TxReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (k <= m_end) begin
                check({tag, "_cyclecount"}, s_cc, k);
                check({tag, "_busy_run"}, s_busy, 1);
                check({tag, "_anyerror_run"}, s_any, exp_any_at(k));
            end
            if (s_valid && first_v < 0) begin
                first_v = k;
                check({tag, "_first_valid_cycle"}, k, m_end + 2);
            end
            if (abort_after > 0 && got.size() == abort_after) begin
                Start = 1'b0; Done = '0; Error = '0; bus.TxReady = 1'b1;
                Rst_n = 1'b0;
                tick();
                Rst_n = 1'b1;
                hold_pend = 1'b0;
                tick();
                check({tag, "_rst_txvalid"}, s_valid, 0);
                check({tag, "_rst_txdata"}, s_data, 0);
                check({tag, "_rst_busy"}, s_busy, 0);
                check({tag, "_rst_finished"}, s_fin, 0);
                check({tag, "_rst_anyerror"}, s_any, 0);
                check({tag, "_rst_timedout"}, s_to, 0);
                check({tag, "_rst_cyclecount"}, s_cc, 0);
                return;
            end
            fin = s_fin;
        end
        Start = 1'b0;
        check({tag, "_finished_reached"}, fin, 1);
        if (fin) begin
            check({tag, "_anyerror_end"}, s_any, m_any);
            check({tag, "_timedout_end"}, s_to, m_to);
            check({tag, "_busy_end"}, s_busy, 0);
            check({tag, "_txvalid_end"}, s_valid, 0);
            check({tag, "_cyclecount_end"}, s_cc, m_end + 1);
            check({tag, "_stream_len"}, got.size(), exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i < got.size())
                    check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{9,  2'b01, 16'h00AB,  5, 2'b01, 16'h1234, 8'h40, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{3,  2'b11, 16'h5555,  4, 2'b01, 16'h0001, 8'h80, 8'h41, 1'b1, 1'b0};
        vecs[2] = '{4,  2'b01, 16'h0005, -1, 2'b00, 16'h0000, 8'h40, 8'h01, 1'b0, 1'b1};
        vecs[3] = '{2,  2'b01, 16'hBEEF, 19, 2'b01, 16'h0F0F, 8'h40, 8'h41, 1'b0, 1'b0};
        vecs[4] = '{-1, 2'b00, 16'h0000,  0, 2'b10, 16'hFFFF, 8'h00, 8'h81, 1'b1, 1'b1};
        vecs[5] = '{7,  2'b01, 16'h00C3,  7, 2'b10, 16'h0102, 8'h40, 8'h81, 1'b1, 1'b0};

        Rst_n = 1'b0; Start = 1'b0; Done = '0; Error = '0; Answer = '0;
        bus.TxReady = 1'b0;
        hold_pend = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tick();
        check("reset_txvalid", s_valid, 0);
        check("reset_txdata", s_data, 0);
        check("reset_busy", s_busy, 0);
        check("reset_finished", s_fin, 0);
        check("reset_anyerror", s_any, 0);
        check("reset_timedout", s_to, 0);
        check("reset_cyclecount", s_cc, 0);
        Rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            load_vec(vecs[v]);
            run_case($sformatf("vec%0d", v), 1'b0, 0);
            check($sformatf("vec%0d_hdr0", v), got.size() > 0 ? got[0] : 8'hxx, vecs[v].hdr0);
            check($sformatf("vec%0d_hdr1", v), got.size() > REC ? got[REC] : 8'hxx, vecs[v].hdr1);
            check($sformatf("vec%0d_any_tbl", v), s_any, vecs[v].any);
            check($sformatf("vec%0d_to_tbl", v), s_to, vecs[v].to);
`ifdef RESULT_MONITOR_CYCLES_EN
            if (v == 5) begin
                for (int b = 0; b < 4; b++)
                    check($sformatf("stamp7_byte%0d", b),
                          got.size() > 3 + b ? got[3 + b] : 8'hxx, (b == 0) ? 8'h07 : 8'h00);
            end
`endif
        end

        load_vec(vecs[0]);
        run_case("midreset", 1'b0, 3);
        load_vec(vecs[0]);
        run_case("after_reset", 1'b0, 0);

        for (int r = 0; r < 12; r++) begin
            load_random();
            run_case($sformatf("rnd%0d", r), 1'b1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_monitor.md
Name: result_monitor

Overview:
- Synthesizable successor to the single-solver completion check.
- Watches NUM_CH solver channels, each with Done, Error and an ANS_W-bit Answer.
- Latches each channel's first completion, enforces a global timeout, then streams one result record per channel over a byte valid/ready interface.
- Sits in Top between the solver instances and the host-reporting path (UART or sim byte sink).

Parameters:
NUM_CH, 2, number of solver channels monitored (1..64)
ANS_W, 64, answer width per channel in bits (8..64)
TIMEOUT_CYCLES, 1000000, cycles after Start before forced report; 0 disables the timeout
CNT_W, 32, cycle counter width

Ports:
Clk  in  1  clock
Rst_n  in  1  synchronous active-low reset
Start  in  1  single-cycle pulse; arms the monitor (accepted only in IDLE or FINISHED)
Done  in  NUM_CH  per-channel completion, level or pulse
Error  in  NUM_CH  per-channel error, level or pulse
Answer  in  NUM_CH*ANS_W  per-channel answer; channel i occupies bits [i*ANS_W +: ANS_W]
TxData  out  8  record byte
TxValid  out  1  TxData valid
TxReady  in  1  sink accepts byte
Busy  out  1  high in RUN and REPORT
Finished  out  1  high in FINISHED
AnyError  out  1  sticky; OR of latched channel errors
TimedOut  out  1  sticky; the timeout fired
CycleCount  out  CNT_W  cycles counted since Start; saturates at all-ones

Behaviour:
- Reset (Rst_n low at a Clk edge): state IDLE; all outputs 0; latched status, answers and counter cleared. Reset overrides any state, including mid-REPORT; a partially sent record is abandoned and TxValid drops the next cycle.
- States:
  - IDLE: Start -> RUN. All latches and CycleCount clear in the same edge.
  - RUN: CycleCount increments each cycle and saturates at all-ones.
    - For each not-yet-latched channel i, if Done[i] or Error[i] is high, latch Answer[i] and status in that same cycle.
    - Status encoding: 2'b10 if Error[i] is high (Error wins when Done and Error rise together); else 2'b01.
    - Later Done/Error edges on a latched channel are ignored.
    - RUN -> REPORT when all channels are latched, or when CycleCount == TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES != 0. On timeout, TimedOut=1 and unlatched channels report status 2'b00 with answer 0.
    - If both conditions hold in one cycle, TimedOut stays 0.
  - REPORT: emit records for channel 0 to NUM_CH-1 in order. Each record is:
    - header byte: {status[1:0], channel_index[5:0]};
    - then ceil(ANS_W/8) answer bytes, LSB first, upper pad bits 0.
    - After the last byte of the last record is accepted -> FINISHED.
  - FINISHED: Finished=1 and all latches hold. Start -> RUN, re-armed as in IDLE.
- Start is ignored in RUN and REPORT.
- Byte handshake: a byte transfers on a cycle with TxValid&TxReady. While TxValid&!TxReady, TxData is held stable. TxValid is never deasserted without a transfer, except on reset. Back-to-back bytes at 1 byte/cycle when TxReady is held high.
- Latency: first TxValid appears the cycle after the REPORT transition.
- AnyError updates in the cycle after the latching edge. AnyError and TimedOut stay valid through FINISHED and clear on Start or reset.

Optional Feature:
RESULT_MONITOR_CYCLES_EN
- Defined: each channel latches CycleCount at its completion. The record gains 4 stamp bytes after the answer, LSB first: the low 32 bits, or CycleCount zero-extended when CNT_W<32. Timed-out channels stamp all-ones.
- Undefined: no stamp storage; records are header + answer only.

Decomposition:
- Package result_monitor_pkg:
  - state enum (IDLE, RUN, REPORT, FINISHED);
  - status codes ST_NONE=2'b00, ST_DONE=2'b01, ST_ERR=2'b10;
  - function computing bytes-per-record from ANS_W and the macro.
- Sub-module result_serializer: takes a record index and byte index, muxes header/answer/stamp bytes, owns the valid/ready hold logic. The top level owns latching, the counter and the FSM.

Test Plan:
- NUM_CH=2, ANS_W=16. Ch1 Done with Answer=0x1234 at cycle 5; ch0 Done with Answer=0x00AB at cycle 9; TxReady=1. Expect stream 0x40,0xAB,0x00,0x41,0x34,0x12, then Finished=1, AnyError=0, TimedOut=0.
- Ch0 Done and Error high in the same cycle. Expect ch0 header 0x80 and AnyError=1 one cycle later.
- TIMEOUT_CYCLES=20; only ch0 completes (Answer=0x0005). Expect TimedOut=1 and REPORT entered at CycleCount=19. Stream 0x40,0x05,0x00,0x01,0x00,0x00.
- TxReady toggled randomly (50%) during REPORT. TxData must be stable whenever TxValid&!TxReady, and the full 6-byte stream arrives in order with no duplicates.
- Rst_n low for 1 cycle after the 3rd byte. Next cycle: TxValid=0, state IDLE, all outputs 0. A new Start reruns cleanly.
- RESULT_MONITOR_CYCLES_EN defined, ch0 Done at CycleCount=7. Record includes stamp bytes 0x07,0x00,0x00,0x00 after the answer.
